cache_req_arbiter: RTL

- Sequences all accesses to the direct-mapped cache and shares its single lookup port between two requesters: requester 0 (instruction fetch) and requester 1 (data / trace driver).
- Arbitrates between the two requesters round-robin and performs the lookup.
- On a miss, stalls for the fill latency, pulses the fill strobe, then retries the lookup.
- Returns read data over a valid/ready handshake and keeps hit/miss statistics for trace runs.

---
 rtl/cache_req_arbiter_if.sv | 29 ++
 rtl/cache_req_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/cache_req_arbiter_if.sv
// Requester/response and cache lookup signals for the cache request arbiter.
// slave = arbiter side, master = requesters plus cache model side.
interface cache_req_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          cache_en;
    logic [AW-1:0] cache_addr;
    logic          cache_hit;
    logic [DW-1:0] cache_rdata;
    logic          cache_fill;

    modport slave (
        input  req_valid, req_addr0, req_addr1, rsp_ready, cache_hit, cache_rdata,
        output req_ready, rsp_valid, rsp_data, cache_en, cache_addr, cache_fill
    );

    modport master (
        output req_valid, req_addr0, req_addr1, rsp_ready, cache_hit, cache_rdata,
        input  req_ready, rsp_valid, rsp_data, cache_en, cache_addr, cache_fill
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing the single cache lookup port between fetch (0) and data (1),
// with miss stall, fill strobe, retry lookup and saturating hit/miss statistics.
module cache_req_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MISS_LAT = 8,
    parameter int CW       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_req_arbiter_if.slave  bus,
    input  logic                clr_stats,
    output logic [CW-1:0]       hit_count,
    output logic [CW-1:0]       miss_count,
    output logic                busy
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_MISS_WAIT = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    localparam logic [7:0]    WAIT_INIT = 8'(MISS_LAT - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    logic [2:0]    state;
    logic [AW-1:0] addr_q;
    logic          gnt_q;
    logic          last_grant;
    logic          retry_q;
    logic [7:0]    wait_cnt;
    logic [DW-1:0] rsp_data_q;

    logic grant;
    logic pick;
    logic hit_inc;
    logic miss_inc;

    // On a tie the requester that did not win last time goes next; otherwise the lone requester.
    assign pick  = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
    // Gated by rst_n so req_ready is also 0 while reset is held.
    assign grant = rst_n && (state == S_IDLE) && (|bus.req_valid);

    assign hit_inc  = (state == S_LOOKUP) &&  bus.cache_hit && !retry_q;
    assign miss_inc = (state == S_LOOKUP) && !bus.cache_hit && !retry_q;

    assign bus.req_ready  = grant ? (pick ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid  = (state == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.cache_en   = (state == S_LOOKUP);
    assign bus.cache_fill = (state == S_FILL);
    assign bus.cache_addr = busy ? addr_q : '0;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
            retry_q    <= 1'b0;
            wait_cnt   <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        addr_q     <= pick ? bus.req_addr1 : bus.req_addr0;
                        gnt_q      <= pick;
                        last_grant <= pick;
                        state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (bus.cache_hit) begin
                        rsp_data_q <= bus.cache_rdata;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    // Counter starts at MISS_LAT-1 so residency is exactly MISS_LAT cycles.
                    if (wait_cnt == 8'd0) state <= S_FILL;
                    else                  wait_cnt <= wait_cnt - 8'd1;
                end
                S_FILL: begin
                    retry_q <= 1'b1;
                    state   <= S_LOOKUP;
                end
                S_RESP: begin
                    if (bus.rsp_ready[gnt_q]) begin
                        retry_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Only first-attempt lookups are counted; clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (clr_stats) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && hit_count != CNT_MAX)   hit_count  <= hit_count + 1'b1;
            if (miss_inc && miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
        end
    end
endmodule
